stepclock: RTL and testbench
============================

# stepclock

Synchronous step-clock generator: produces the low-to-high `clk_out` transitions that downstream positive-edge gates consume, plus aligned strobes. It sits between the front-panel run/step controls and the CPU clock network, supporting free-run, single-step and clean halt. `clk_out` changes only at a period boundary and never glitches or truncates a phase.

## Interface
Parameters:
- `HIGH_CYCLES`, default 2: `clk` cycles `clk_out` stays high; must be at least 1.
- `LOW_CYCLES`, default 2: `clk` cycles `clk_out` stays low; must be at least 1.
- `CNT_W`, default 16: width of the completed-period counter.

Ports:
- `clk`, in, 1: system clock; every register is on its rising edge.
- `rst`, in, 1: reset, synchronous and active-high.
- `run`, in, 1: level; generate periods continuously while high.
- `step`, in, 1: one-cycle request for exactly one period.
- `halt`, in, 1: level; stop at the next period end. Has priority over `run` and `step`.
- `clk_out`, out, 1: generated clock, registered.
- `rise`, out, 1: high in the cycle `clk_out` first reads 1 in a period.
- `fall`, out, 1: high in the cycle `clk_out` first reads 0 after HIGH.
- `busy`, out, 1: high while in HIGH or LOW.
- `count`, out, `CNT_W`: completed periods, modulo 2^`CNT_W`.

## Operation
States:
- **IDLE**: `clk_out` = 0.
  - Go to HIGH when (`run` or `step` or `pend`) and not `halt`.
- **HIGH**: `clk_out` = 1.
  - Go to LOW after `HIGH_CYCLES` cycles.
- **LOW**: `clk_out` = 0.
  - After `LOW_CYCLES` cycles the period ends: `count` increments.
  - Go to HIGH (no IDLE gap) if not `halt` and (`run` or `pend`); otherwise go to IDLE.

Step handling:
- `pend` is a one-deep step latch.
- `step` in IDLE without `halt` starts a period directly; `pend` is not set.
- `step` while busy sets `pend`. Further steps while `pend` = 1 are dropped.
- `pend` is cleared when it launches a period.
- `pend` is also cleared when a period ends with `halt` = 1.

Halt:
- `halt` asserted mid-period does not shorten the period.
- It takes effect only at the LOW-end decision.
- `step` and `halt` in the same IDLE cycle: `step` is discarded.

Run:
- `run` dropping mid-period completes that period, then goes to IDLE unless `pend` is set.

Reset (`rst` = 1):
- Next cycle: IDLE, `clk_out` = `rise` = `fall` = `busy` = 0, `count` = 0, `pend` = 0.
- Applies mid-period too. No `fall` strobe is generated for a truncated period.

Counter:
- `count` wraps from 2^`CNT_W`−1 to 0 with no flag.

## Timing
- Every output is a register output; no combinational path from inputs to outputs.
- Start latency: `step`/`run` sampled in IDLE at cycle t gives `clk_out` = 1 and `rise` = 1 at t+1.
- Period length is exactly `HIGH_CYCLES` + `LOW_CYCLES` cycles.
- Back-to-back periods keep that length, with no extra LOW cycle.
- `fall` occurs at t+1+`HIGH_CYCLES`.
- `count` shows its new value at t+1+`HIGH_CYCLES`+`LOW_CYCLES`. That is the same cycle as the next `rise` when continuing.
- `busy` equals (state is not IDLE) and is aligned with `clk_out` ownership: high from the `rise` cycle through the last LOW cycle.
- `rise` and `fall` are each exactly one cycle wide and never coincide.
- With `HIGH_CYCLES` = `LOW_CYCLES` = 1, `clk_out` toggles every cycle while running.

## Structure
- Shared header `stepclock_defs`:
  - State encoding: IDLE = 2'b00, HIGH = 2'b01, LOW = 2'b10. 2'b11 is illegal and recovers to IDLE.
  - Phase-counter width: clog2 of max(`HIGH_CYCLES`, `LOW_CYCLES`).
- Sub-module `phase_timer`:
  - Loadable down-counter with a `done` flag.
  - Loaded with `HIGH_CYCLES`−1 on entry to HIGH and `LOW_CYCLES`−1 on entry to LOW.
  - `done` = counter equals zero.
- The top level holds the FSM, `pend`, the output registers and `count`.

## Test plan
All scenarios use defaults (H = L = 2) unless stated.
1. Reset, then `step` for 1 cycle at t=10 -> `rise` at 11; `clk_out` high 11–12; `fall` at 13; low 13–14; `count` = 1 and `busy` = 0 at 15.
2. `run` held 20 cycles from t=0 -> `clk_out` has period 4 and 50% duty with no gap; `count` increments every 4 cycles; deassert `run` mid-HIGH -> that period completes, then IDLE.
3. `step` at t=0, second `step` at t=2, third at t=3 -> exactly 2 periods, back-to-back, `count` = 2.
4. `run` = 1, `halt` raised at the second cycle of HIGH -> current period completes in full; `clk_out` stays 0 afterwards; `step` + `halt` in IDLE -> no `rise`.
5. `rst` at the middle cycle of LOW -> next cycle all outputs 0, `count` = 0, no `fall`; with `CNT_W` = 2 and `run` for 5 periods -> `count` sequence 1, 2, 3, 0, 1.
6. H = L = 1, `run` -> `clk_out` toggles every cycle; `rise`/`fall` alternate every cycle.

Source files
------------

// File: rtl/stepclock_pkg.sv
// stepclock_pkg
//   Shared definitions for the step-clock generator: the FSM state
//   encoding and the sizing helper for the per-phase down-counter.
//   No ports; imported by the top level.
package stepclock_pkg;

  // 2'b11 is deliberately left unnamed; the FSM falls back to IDLE from it.
  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_HIGH = 2'b01,
    ST_LOW  = 2'b10
  } state_t;

  // Bits needed to hold max(high, low) - 1, never less than one bit so the
  // timer stays a legal vector when both phases are a single cycle.
  function automatic int phaseWidth(input int highCycles, input int lowCycles);
    int m;
    m = (highCycles > lowCycles) ? highCycles : lowCycles;
    if (m <= 2) return 1;
    return $clog2(m);
  endfunction

endpackage

// File: rtl/stepclock_if.sv
// stepclock_if
//   Bundles the front-panel controls and the generated-clock outputs.
//   master: drives run/step/halt, observes clk_out/rise/fall/busy/count.
//   slave : the generator side (inputs run/step/halt, drives the rest).
//   Parameter CNT_W sets the width of the completed-period counter.
interface stepclock_if #(
  parameter int CNT_W = 16
);
  logic             run;
  logic             step;
  logic             halt;
  logic             clk_out;
  logic             rise;
  logic             fall;
  logic             busy;
  logic [CNT_W-1:0] count;

  modport master (
    output run, step, halt,
    input  clk_out, rise, fall, busy, count
  );

  modport slave (
    input  run, step, halt,
    output clk_out, rise, fall, busy, count
  );
endinterface

// File: rtl/stepclock_phase_timer.sv
// phase_timer
//   Loadable down-counter that times one HIGH or LOW phase.
//   Ports: clk, rst (sync, active-high), i_load/i_value load the counter,
//          o_done is high while the counter reads zero.
//   Loading value N-1 makes o_done rise on the N-th cycle of the phase.
module phase_timer #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_load,
  input  logic [WIDTH-1:0] i_value,
  output logic             o_done
);

  logic [WIDTH-1:0] r_count;

  // Counts down and parks at zero; a load always wins.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_count <= '0;
    end else if (i_load) begin
      r_count <= i_value;
    end else if (r_count != '0) begin
      r_count <= r_count - WIDTH'(1);
    end
  end

  assign o_done = (r_count == '0);

endmodule

// File: rtl/stepclock.sv
// stepclock
//   Step-clock generator for the CPU clock network: free-run, single-step
//   and clean halt, with clk_out changing only at phase boundaries.
//   Ports: clk, rst (sync, active-high), bus (stepclock_if.slave):
//     run/step/halt in; clk_out, rise, fall, busy, count out.
//   Parameters: HIGH_CYCLES, LOW_CYCLES (>= 1), CNT_W (counter width).
module stepclock
  import stepclock_pkg::*;
#(
  parameter int HIGH_CYCLES = 2,
  parameter int LOW_CYCLES  = 2,
  parameter int CNT_W       = 16
) (
  input  logic         clk,
  input  logic         rst,
  stepclock_if.slave   bus
);

  localparam int PHASE_W = phaseWidth(HIGH_CYCLES, LOW_CYCLES);
  localparam logic [PHASE_W-1:0] HIGH_LOAD = PHASE_W'(HIGH_CYCLES - 1);
  localparam logic [PHASE_W-1:0] LOW_LOAD  = PHASE_W'(LOW_CYCLES - 1);

  state_t             r_state;
  state_t             w_stateNext;
  logic               r_pend;
  logic               w_pendNext;
  logic               w_load;
  logic [PHASE_W-1:0] w_loadVal;
  logic               w_phaseDone;
  logic               w_periodEnd;
  logic               r_clkOut;
  logic               r_rise;
  logic               r_fall;
  logic               r_busy;
  logic [CNT_W-1:0]   r_count;

  phase_timer #(.WIDTH(PHASE_W)) u_timer (
    .clk     (clk),
    .rst     (rst),
    .i_load  (w_load),
    .i_value (w_loadVal),
    .o_done  (w_phaseDone)
  );

  // Next-state, step latch and timer load. The timer is reloaded on every
  // phase entry, including the LOW->HIGH hop of back-to-back periods.
  // halt is only looked at in IDLE and at the end of LOW, so a period in
  // flight always runs to completion.
  always_comb begin
    w_stateNext = r_state;
    w_pendNext  = r_pend;
    w_load      = 1'b0;
    w_loadVal   = HIGH_LOAD;
    w_periodEnd = 1'b0;
    case (r_state)
      ST_IDLE: begin
        // A direct step start never touches pend; step with halt is lost.
        if (!bus.halt && (bus.run || bus.step || r_pend)) begin
          w_stateNext = ST_HIGH;
          w_load      = 1'b1;
          w_loadVal   = HIGH_LOAD;
          w_pendNext  = 1'b0;
        end
      end
      ST_HIGH: begin
        if (bus.step) w_pendNext = 1'b1;
        if (w_phaseDone) begin
          w_stateNext = ST_LOW;
          w_load      = 1'b1;
          w_loadVal   = LOW_LOAD;
        end
      end
      ST_LOW: begin
        if (bus.step) w_pendNext = 1'b1;
        if (w_phaseDone) begin
          w_periodEnd = 1'b1;
          if (bus.halt) begin
            w_stateNext = ST_IDLE;
            w_pendNext  = 1'b0;
          end else if (r_pend) begin
            // The latched step is consumed by the period it launches.
            w_stateNext = ST_HIGH;
            w_load      = 1'b1;
            w_loadVal   = HIGH_LOAD;
            w_pendNext  = 1'b0;
          end else if (bus.run) begin
            w_stateNext = ST_HIGH;
            w_load      = 1'b1;
            w_loadVal   = HIGH_LOAD;
          end else begin
            w_stateNext = ST_IDLE;
          end
        end
      end
      default: begin
        w_stateNext = ST_IDLE;
        w_pendNext  = 1'b0;
      end
    endcase
  end

  // Outputs are registered from the next state so clk_out, the strobes and
  // busy all line up with the state they describe, with no input-to-output
  // combinational path.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= ST_IDLE;
      r_pend   <= 1'b0;
      r_clkOut <= 1'b0;
      r_rise   <= 1'b0;
      r_fall   <= 1'b0;
      r_busy   <= 1'b0;
      r_count  <= '0;
    end else begin
      r_state  <= w_stateNext;
      r_pend   <= w_pendNext;
      r_clkOut <= (w_stateNext == ST_HIGH);
      r_rise   <= (w_stateNext == ST_HIGH) && (r_state != ST_HIGH);
      r_fall   <= (w_stateNext == ST_LOW) && (r_state == ST_HIGH);
      r_busy   <= (w_stateNext != ST_IDLE);
      if (w_periodEnd) r_count <= r_count + CNT_W'(1);
    end
  end

  assign bus.clk_out = r_clkOut;
  assign bus.rise    = r_rise;
  assign bus.fall    = r_fall;
  assign bus.busy    = r_busy;
  assign bus.count   = r_count;

endmodule

// File: tb/tb_stepclock.sv
// tb_stepclock
//   Directed bench for stepclock. Three instances share clk/rst:
//   dutA uses the defaults, dutB has a 2-bit counter, dutC has H = L = 1.
//   Inputs change #1 after a rising edge; outputs are sampled at that same
//   point, so each tick() advances exactly one clk cycle.
module tb_stepclock;

  logic clk = 1'b0;
  logic rst;
  int   testsRun    = 0;
  int   testsFailed = 0;

  always #5 clk = ~clk;

  stepclock_if                 ifA ();
  stepclock_if #(.CNT_W(2))    ifB ();
  stepclock_if                 ifC ();

  stepclock dutA (
    .clk (clk),
    .rst (rst),
    .bus (ifA.slave)
  );

  stepclock #(.CNT_W(2)) dutB (
    .clk (clk),
    .rst (rst),
    .bus (ifB.slave)
  );

  stepclock #(.HIGH_CYCLES(1), .LOW_CYCLES(1)) dutC (
    .clk (clk),
    .rst (rst),
    .bus (ifC.slave)
  );

  // Single point of comparison: counts and reports every check.
  task automatic checkOutput(input string tag, input logic [31:0] actual,
                             input logic [31:0] expected);
    testsRun++;
    if (actual !== expected) begin
      testsFailed++;
      $display("[TB] FAIL %s: got %0d, expected %0d", tag, actual, expected);
    end
  endtask

  // Drives the control inputs of one instance (0 = A, 1 = B, 2 = C).
  task automatic applyStimulus(input int sel, input logic run,
                               input logic step, input logic halt);
    case (sel)
      0: begin ifA.run = run; ifA.step = step; ifA.halt = halt; end
      1: begin ifB.run = run; ifB.step = step; ifB.halt = halt; end
      default: begin ifC.run = run; ifC.step = step; ifC.halt = halt; end
    endcase
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Compares all five outputs of one instance against expected values.
  task automatic checkBus(input int sel, input string tag, input logic eClk,
                          input logic eRise, input logic eFall,
                          input logic eBusy, input logic [31:0] eCount);
    logic        o, r, f, b;
    logic [31:0] c;
    case (sel)
      0: begin
        o = ifA.clk_out; r = ifA.rise; f = ifA.fall; b = ifA.busy;
        c = 32'(ifA.count);
      end
      1: begin
        o = ifB.clk_out; r = ifB.rise; f = ifB.fall; b = ifB.busy;
        c = 32'(ifB.count);
      end
      default: begin
        o = ifC.clk_out; r = ifC.rise; f = ifC.fall; b = ifC.busy;
        c = 32'(ifC.count);
      end
    endcase
    checkOutput({tag, ".clk_out"}, 32'(o), 32'(eClk));
    checkOutput({tag, ".rise"},    32'(r), 32'(eRise));
    checkOutput({tag, ".fall"},    32'(f), 32'(eFall));
    checkOutput({tag, ".busy"},    32'(b), 32'(eBusy));
    checkOutput({tag, ".count"},   c,      eCount);
  endtask

  task automatic doReset();
    applyStimulus(0, 1'b0, 1'b0, 1'b0);
    applyStimulus(1, 1'b0, 1'b0, 1'b0);
    applyStimulus(2, 1'b0, 1'b0, 1'b0);
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  initial begin
    int ph;
    int expB[5];
    expB = '{1, 2, 3, 0, 1};

    // Reset state of every instance.
    doReset();
    checkBus(0, "rst.A", 0, 0, 0, 0, 0);
    checkBus(1, "rst.B", 0, 0, 0, 0, 0);
    checkBus(2, "rst.C", 0, 0, 0, 0, 0);

    // Single step: rise, two HIGH, two LOW, then idle with count 1.
    for (int i = 0; i < 8; i++) tick();
    applyStimulus(0, 1'b0, 1'b1, 1'b0);
    tick(); checkBus(0, "s1.t11", 1, 1, 0, 1, 0);
    applyStimulus(0, 1'b0, 1'b0, 1'b0);
    tick(); checkBus(0, "s1.t12", 1, 0, 0, 1, 0);
    tick(); checkBus(0, "s1.t13", 0, 0, 1, 1, 0);
    tick(); checkBus(0, "s1.t14", 0, 0, 0, 1, 0);
    tick(); checkBus(0, "s1.t15", 0, 0, 0, 0, 1);
    tick(); checkBus(0, "s1.t16", 0, 0, 0, 0, 1);

    // Free run: period 4, no gap, count steps on each new rise.
    doReset();
    applyStimulus(0, 1'b1, 1'b0, 1'b0);
    for (int k = 1; k <= 20; k++) begin
      tick();
      ph = (k - 1) % 4;
      checkBus(0, $sformatf("s2.k%0d", k), ph < 2, ph == 0, ph == 2, 1,
               32'((k - 1) / 4));
    end
    tick(); checkBus(0, "s2.k21", 1, 1, 0, 1, 5);
    applyStimulus(0, 1'b0, 1'b0, 1'b0);
    tick(); checkBus(0, "s2.k22", 1, 0, 0, 1, 5);
    tick(); checkBus(0, "s2.k23", 0, 0, 1, 1, 5);
    tick(); checkBus(0, "s2.k24", 0, 0, 0, 1, 5);
    tick(); checkBus(0, "s2.k25", 0, 0, 0, 0, 6);
    tick(); checkBus(0, "s2.k26", 0, 0, 0, 0, 6);

    // Steps at t=0, 2, 3: second latches pend, third is dropped.
    doReset();
    applyStimulus(0, 1'b0, 1'b1, 1'b0);
    tick(); checkBus(0, "s3.t1", 1, 1, 0, 1, 0);
    applyStimulus(0, 1'b0, 1'b0, 1'b0);
    tick(); checkBus(0, "s3.t2", 1, 0, 0, 1, 0);
    applyStimulus(0, 1'b0, 1'b1, 1'b0);
    tick(); checkBus(0, "s3.t3", 0, 0, 1, 1, 0);
    tick(); checkBus(0, "s3.t4", 0, 0, 0, 1, 0);
    applyStimulus(0, 1'b0, 1'b0, 1'b0);
    tick(); checkBus(0, "s3.t5", 1, 1, 0, 1, 1);
    tick(); checkBus(0, "s3.t6", 1, 0, 0, 1, 1);
    tick(); checkBus(0, "s3.t7", 0, 0, 1, 1, 1);
    tick(); checkBus(0, "s3.t8", 0, 0, 0, 1, 1);
    tick(); checkBus(0, "s3.t9", 0, 0, 0, 0, 2);
    tick(); checkBus(0, "s3.t10", 0, 0, 0, 0, 2);

    // Halt raised mid-HIGH: period completes, then stays low.
    doReset();
    applyStimulus(0, 1'b1, 1'b0, 1'b0);
    tick(); checkBus(0, "s4.t1", 1, 1, 0, 1, 0);
    tick(); checkBus(0, "s4.t2", 1, 0, 0, 1, 0);
    applyStimulus(0, 1'b1, 1'b0, 1'b1);
    tick(); checkBus(0, "s4.t3", 0, 0, 1, 1, 0);
    tick(); checkBus(0, "s4.t4", 0, 0, 0, 1, 0);
    tick(); checkBus(0, "s4.t5", 0, 0, 0, 0, 1);
    tick(); checkBus(0, "s4.t6", 0, 0, 0, 0, 1);
    applyStimulus(0, 1'b1, 1'b1, 1'b1);
    tick(); checkBus(0, "s4.t7", 0, 0, 0, 0, 1);
    applyStimulus(0, 1'b0, 1'b0, 1'b0);
    tick(); checkBus(0, "s4.t8", 0, 0, 0, 0, 1);
    tick(); checkBus(0, "s4.t9", 0, 0, 0, 0, 1);

    // Reset in the middle of LOW truncates the period with no strobes.
    doReset();
    applyStimulus(0, 1'b1, 1'b0, 1'b0);
    for (int k = 1; k <= 4; k++) tick();
    tick(); checkBus(0, "s5.t5", 1, 1, 0, 1, 1);
    tick();
    tick(); checkBus(0, "s5.t7", 0, 0, 1, 1, 1);
    rst = 1'b1;
    applyStimulus(0, 1'b0, 1'b0, 1'b0);
    tick(); checkBus(0, "s5.t8", 0, 0, 0, 0, 0);
    rst = 1'b0;
    tick(); checkBus(0, "s5.t9", 0, 0, 0, 0, 0);

    // 2-bit counter wraps: 1, 2, 3, 0, 1.
    doReset();
    applyStimulus(1, 1'b1, 1'b0, 1'b0);
    for (int k = 1; k <= 21; k++) begin
      tick();
      if ((k % 4 == 1) && (k > 1))
        checkOutput($sformatf("s5w.k%0d.count", k), 32'(ifB.count),
                    32'(expB[(k - 1) / 4 - 1]));
    end
    applyStimulus(1, 1'b0, 1'b0, 1'b0);
    for (int k = 22; k <= 25; k++) tick();
    checkBus(1, "s5w.k25", 0, 0, 0, 0, 2);

    // H = L = 1: clk_out toggles every cycle, rise/fall alternate.
    doReset();
    applyStimulus(2, 1'b1, 1'b0, 1'b0);
    for (int k = 1; k <= 8; k++) begin
      tick();
      checkBus(2, $sformatf("s6.k%0d", k), k % 2 == 1, k % 2 == 1,
               k % 2 == 0, 1, 32'((k - 1) / 2));
    end
    applyStimulus(2, 1'b0, 1'b0, 1'b0);
    tick(); checkBus(2, "s6.k9", 0, 0, 0, 0, 4);

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
